// File: rtl/cnna_mul_share_pkg.sv
// Shared constants and types for the round-robin multiplier-sharing block.
// The S1 record carries one accepted operand pair through the operand register.
package cnna_mul_share_pkg;

  localparam int CNNA_MS_A_W      = 5;
  localparam int CNNA_MS_B_W      = 15;
  localparam int CNNA_MS_P_W      = 16;
  // Wide enough for any requester count the block supports (up to 8).
  localparam int CNNA_MS_ID_MAX_W = 3;

  typedef logic [CNNA_MS_ID_MAX_W-1:0] cnna_ms_id_t;

  typedef struct packed {
    logic [CNNA_MS_A_W-1:0] a;
    logic [CNNA_MS_B_W-1:0] b;
    cnna_ms_id_t            id;
    logic                   v;
  } cnna_ms_s1_t;

  function automatic int cnna_ms_clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) res++;
    return res;
  endfunction

endpackage

// File: rtl/cnna_mul_mul_5ns_15ns_16_1_1.sv
// Shared unsigned 5x15 multiplier core with a truncated 16-bit product.
// Single-stage variant: the product is purely combinational on its inputs.
module cnna_mul_mul_5ns_15ns_16_1_1 #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 1,
  parameter int din0_WIDTH = 5,
  parameter int din1_WIDTH = 15,
  parameter int dout_WIDTH = 16
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  localparam int FULL_W = din0_WIDTH + din1_WIDTH;

  // Only the single-stage, valid-ID configuration exists; anything else outputs zero.
  if (NUM_STAGE == 1 && ID >= 0) begin : g_comb
    assign dout = dout_WIDTH'(FULL_W'(din0) * FULL_W'(din1));
  end else begin : g_none
    assign dout = '0;
  end

endmodule

// File: rtl/cnna_rr_arb.sv
// Combinational round-robin arbiter: first set request at or above ptr_i, wrapping.
// The pointer itself lives in the parent so it only moves on a real handshake.
module cnna_rr_arb
  import cnna_mul_share_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = cnna_ms_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o
);

  int              cand;
  logic [ID_W-1:0] cand_idx;
  logic            found;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand     = (int'(ptr_i) + off) % NUM_REQ;
      cand_idx = ID_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found = 1'b1;
        idx_o = cand_idx;
      end
    end
    if (en_i && found) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/cnna_mul_share_arb.sv
// Shares one 5x15 multiplier among NUM_REQ requesters with round-robin grant,
// a registered operand stage (S1) and a registered result stage (OUT).
module cnna_mul_share_arb
  import cnna_mul_share_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int A_W     = CNNA_MS_A_W,
  parameter  int B_W     = CNNA_MS_B_W,
  parameter  int P_W     = CNNA_MS_P_W,
  localparam int ID_W    = cnna_ms_clog2(NUM_REQ)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [P_W-1:0]         rsp_p
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; ready never depends on the same requester's operands, only on pipe space.

  cnna_ms_s1_t        s1_q, s1_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [P_W-1:0]     rsp_p_q, rsp_p_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

  logic               out_free;
  logic               s1_free;
  logic               arb_en;
  logic               hs;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic [P_W-1:0]     mul_p;

  assign out_free = !rsp_valid_q || rsp_ready;
  assign s1_free  = !s1_q.v || out_free;
  assign arb_en   = s1_free && !ap_rst;

  cnna_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (arb_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign req_ready = gnt;
  assign hs        = |(req_valid & gnt);

  cnna_mul_mul_5ns_15ns_16_1_1 #(
    .ID         (1),
    .NUM_STAGE  (1),
    .din0_WIDTH (A_W),
    .din1_WIDTH (B_W),
    .dout_WIDTH (P_W)
  ) u_mul (
    .din0 (s1_q.a),
    .din1 (s1_q.b),
    .dout (mul_p)
  );

  // Operands are captured only on a handshake, so unselected slices never reach S1.
  always_comb begin
    s1_d        = s1_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_p_d     = rsp_p_q;
    rsp_id_d    = rsp_id_q;

    if (hs) begin
      s1_d.a  = req_a[gnt_idx*A_W +: A_W];
      s1_d.b  = req_b[gnt_idx*B_W +: B_W];
      s1_d.id = cnna_ms_id_t'(gnt_idx);
      s1_d.v  = 1'b1;
      if (gnt_idx == ID_W'(NUM_REQ - 1)) rr_ptr_d = '0;
      else                               rr_ptr_d = gnt_idx + 1'b1;
    end else if (s1_free) begin
      s1_d.v = 1'b0;
    end

    if (out_free) begin
      rsp_valid_d = s1_q.v;
      if (s1_q.v) begin
        rsp_p_d  = mul_p;
        rsp_id_d = ID_W'(s1_q.id);
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_q        <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_p_q     <= '0;
      rsp_id_q    <= '0;
    end else begin
      s1_q        <= s1_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_cnna_mul_share_arb.sv
// Directed bench for cnna_mul_share_arb: hand-computed grants and products,
// with an in-order expected queue drained by a response monitor.
module tb_cnna_mul_share_arb;

  localparam int NUM_REQ = 4;
  localparam int A_W     = 5;
  localparam int B_W     = 15;
  localparam int P_W     = 16;
  localparam int ID_W    = 2;
  localparam int W       = ID_W + P_W;

  logic                   ap_clk;
  logic                   ap_rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [P_W-1:0]         rsp_p;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  int           n_checks;
  int           n_pass;

  cnna_mul_share_arb #(
    .NUM_REQ (NUM_REQ),
    .A_W     (A_W),
    .B_W     (B_W),
    .P_W     (P_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p)
  );

  // Clock and reset
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  // Checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
  endtask

  // Drivers
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [A_W-1:0] a,
                         input logic [B_W-1:0] b);
    req_valid[i]       = v;
    req_a[i*A_W +: A_W] = a;
    req_b[i*B_W +: B_W] = b;
  endtask

  task automatic push_exp(input logic [ID_W-1:0] id, input logic [P_W-1:0] p);
    exp_q.push_back({id, p});
  endtask

  task automatic check_rsp(input string tag, input logic [ID_W-1:0] id,
                           input logic [P_W-1:0] p);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_p"},     32'(rsp_p),     32'(p));
    check({tag, "_id"},    32'(rsp_id),    32'(id));
  endtask

  // Scoreboard: every accepted response must match the next expected one
  always @(negedge ap_clk) begin
    if (!ap_rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_spurious", 32'(rsp_valid), 32'd0);
      end else begin
        exp_w = exp_q.pop_front();
        check("rsp_data", 32'({rsp_id, rsp_p}), 32'(exp_w));
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    ap_rst    = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;

    // Reset state, with all requesters asking
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 5'd1, 15'd1);
    tick();
    tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_p",     32'(rsp_p),     32'd0);
    check("rst_id",    32'(rsp_id),    32'd0);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 5'd0, 15'd0);
    ap_rst = 1'b0;

    // Single request and 2-cycle latency: 3 * 1000
    set_req(0, 1'b1, 5'd3, 15'd1000);
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    push_exp(2'd0, 16'd3000);
    tick();
    set_req(0, 1'b0, 5'd0, 15'd0);
    #1;
    check("single_lat1", 32'(rsp_valid), 32'd0);
    tick();
    check_rsp("single", 2'd0, 16'd3000);
    tick();
    check("single_idle", 32'(rsp_valid), 32'd0);

    // Truncation: 31 * 32767 = 1015777, mod 65536 = 32737
    set_req(3, 1'b1, 5'd31, 15'd32767);
    #1;
    check("trunc_ready", 32'(req_ready), 32'h8);
    push_exp(2'd3, 16'd32737);
    tick();
    set_req(3, 1'b0, 5'd0, 15'd0);
    tick();
    check_rsp("trunc", 2'd3, 16'd32737);
    tick();

    // Contention from reset: grants 0,1,2,3,... products 10,20,30,40 back to back
    ap_rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 5'(i + 1), 15'd10);
    #1;
    check("cont_rst_ready", 32'(req_ready), 32'd0);
    tick();
    ap_rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("cont_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 2) check("cont_b2b_valid", 32'(rsp_valid), 32'd1);
      push_exp(2'(k % 4), 16'(((k % 4) + 1) * 10));
      tick();
    end
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 5'd0, 15'd0);
    tick();
    tick();
    check("cont_drained", 32'(rsp_valid), 32'd0);

    // Backpressure: 5*7 = 35 and 4*9 = 36 held while downstream stalls
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 5'd5, 15'd7);
    set_req(1, 1'b1, 5'd4, 15'd9);
    #1;
    check("bp_ready0", 32'(req_ready), 32'h1);
    push_exp(2'd0, 16'd35);
    tick();
    check("bp_ready1", 32'(req_ready), 32'h2);
    push_exp(2'd1, 16'd36);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_full_ready", 32'(req_ready), 32'd0);
      check_rsp("bp_hold", 2'd0, 16'd35);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'h1);
    push_exp(2'd0, 16'd35);
    tick();
    set_req(0, 1'b0, 5'd0, 15'd0);
    set_req(1, 1'b0, 5'd0, 15'd0);
    check_rsp("bp_second", 2'd1, 16'd36);
    tick();
    check_rsp("bp_third", 2'd0, 16'd35);
    tick();
    check("bp_drained", 32'(rsp_valid), 32'd0);

    // Pointer hold: only req2, then req1 joins and wins after the wrap
    set_req(2, 1'b1, 5'd1, 15'd2);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ptr_grant2", 32'(req_ready), 32'h4);
      push_exp(2'd2, 16'd2);
      tick();
    end
    set_req(1, 1'b1, 5'd3, 15'd3);
    #1;
    check("ptr_grant1", 32'(req_ready), 32'h2);
    push_exp(2'd1, 16'd9);
    tick();
    check("ptr_grant2_again", 32'(req_ready), 32'h4);
    push_exp(2'd2, 16'd2);
    tick();
    set_req(1, 1'b0, 5'd0, 15'd0);
    set_req(2, 1'b0, 5'd0, 15'd0);
    tick();
    tick();
    check("ptr_drained", 32'(rsp_valid), 32'd0);

    // Reset one cycle after a handshake: the in-flight 6*6 is discarded
    set_req(0, 1'b1, 5'd6, 15'd6);
    #1;
    check("mf_hs_ready", 32'(req_ready), 32'h1);
    tick();
    ap_rst = 1'b1;
    #1;
    check("mf_rst_ready", 32'(req_ready), 32'd0);
    tick();
    check("mf_no_out", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 5'(i + 1), 15'd10);
    ap_rst = 1'b0;
    #1;
    check("mf_first_grant", 32'(req_ready), 32'h1);
    check("mf_post_valid", 32'(rsp_valid), 32'd0);
    push_exp(2'd0, 16'd10);
    tick();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 5'd0, 15'd0);
    #1;
    check("mf_no_stale", 32'(rsp_valid), 32'd0);
    tick();
    check_rsp("mf_rsp", 2'd0, 16'd10);
    tick();
    check("mf_drained", 32'(rsp_valid), 32'd0);

    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    // Report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cnna_mul_share_arb.md
Name: cnna_mul_share_arb

Overview:
- Shares one 5-bit x 15-bit unsigned multiplier (cnna_mul_mul_5ns_15ns_16_1_1, 16-bit product) among NUM_REQ requesters, e.g. the CNN address/stride generators.
- Arbitration is round-robin, with a valid/ready handshake per requester.
- Operands and product are registered; each product is returned with the ID of the requester that issued it.
- Sits between the loop-index generators and the buffer address logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- A_W, 5, operand A width (unsigned).
- B_W, 15, operand B width (unsigned).
- P_W, 16, product width; the product is truncated to this width.
- ID_W, clog2(NUM_REQ), requester ID width (derived, not overridable).

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*A_W  packed operand A; requester i occupies bits [i*A_W +: A_W].
- req_b  in  NUM_REQ*B_W  packed operand B; requester i occupies bits [i*B_W +: B_W].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_id  out  ID_W  index of the requester that issued the result.
- rsp_p  out  P_W  product.

Behaviour:
- Reset (ap_rst high at a rising edge):
  - s1_v = 0 and rsp_valid = 0; rsp_p = 0, rsp_id = 0; rr_ptr = 0.
  - req_ready is forced to 0 while ap_rst is high.
  - In-flight operations are discarded and produce no response.
- Pipeline:
  - Stage S1 holds the operand register (s1_a, s1_b, s1_id, s1_v).
  - The multiplier is combinational on the S1 registers.
  - Stage OUT holds the output register (rsp_p, rsp_id, rsp_valid).
- Advance rules:
  - out_free = !rsp_valid | rsp_ready.
  - s1_free = !s1_v | out_free.
- Grant (combinational):
  - The first requester with req_valid set, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready[g] = s1_free & !ap_rst for the granted g; all other req_ready bits are 0.
- A handshake occurs when req_valid[g] & req_ready[g]. On a handshake:
  - S1 loads req_a/req_b slice g and s1_id = g; s1_v = 1.
  - rr_ptr = (g+1) mod NUM_REQ.
- rr_ptr holds whenever there is no handshake.
- When out_free:
  - rsp_valid = s1_v.
  - If s1_v: rsp_p = (s1_a*s1_b) mod 2^P_W, rsp_id = s1_id.
- When s1_free with no handshake, s1_v = 0.
- Latency is exactly 2 cycles from handshake edge to rsp_valid, with no backpressure.
- Throughput is 1 result per cycle sustained.
- Backpressure:
  - While rsp_valid & !rsp_ready, rsp_p, rsp_id and rsp_valid hold stable.
  - S1 holds if full; req_ready is 0 if S1 is full.
  - At most 2 operations are in flight.
- Simultaneous events: rsp_ready and a new handshake in the same cycle both take effect, so the pipeline shifts with no bubble.
- A requester that drops req_valid before a handshake loses nothing. Requests are not latched before the handshake.
- Fairness: every continuously-valid requester is granted within NUM_REQ handshakes.
- Arithmetic:
  - Both operands are unsigned.
  - The full product needs A_W+B_W = 20 bits; the upper bits are discarded by design, matching the shared multiplier's 16-bit output.
- Operands with req_valid = 0 are don't-care; X on them must not propagate to the outputs.

Decomposition:
- Package cnna_mul_share_pkg holds:
  - constants CNNA_MS_A_W = 5, CNNA_MS_B_W = 15, CNNA_MS_P_W = 16;
  - a function for clog2;
  - a typedef for the S1 operand record (a, b, id, v).
- Sub-module cnna_rr_arb:
  - Parameterised by NUM_REQ.
  - Inputs: req vector, rr_ptr, enable. Output: one-hot grant plus encoded index.
  - Purely combinational; rr_ptr is kept in the parent.
- The multiplier is instantiated once as the existing cnna_mul_mul_5ns_15ns_16_1_1 (ID = 1, NUM_STAGE = 1, widths 5/15/16).

Test Plan:
- Single request: req0 with a = 3, b = 1000, rsp_ready = 1. Expect:
  - req_ready[0] = 1 in the same cycle;
  - 2 cycles later rsp_valid = 1, rsp_p = 3000, rsp_id = 0.
- Truncation: a = 31, b = 32767. Expect rsp_p = 32737 (1015777 mod 65536).
- Contention: all 4 requesters valid continuously from reset, each with a = id+1, b = 10. Expect:
  - grants in order 0,1,2,3,0,...;
  - rsp_p sequence 10, 20, 30, 40, ... on back-to-back cycles.
- Backpressure:
  - Hold rsp_ready = 0 for 5 cycles with a stream of requests. Expect rsp_valid/rsp_p/rsp_id stable, one more request accepted into S1, then all req_ready = 0.
  - Release rsp_ready. Expect both results in order with no loss or duplication.
- Pointer hold: only req2 valid. Expect:
  - repeated grants to 2;
  - after req1 also asserts, the next grant goes to 1 only after rr_ptr wraps (3 → 0 → 1), i.e. order 2, 1.
- Reset mid-flight: assert ap_rst one cycle after a handshake. Expect:
  - rsp_valid stays 0 and no stale response after reset is released;
  - req_ready = 0 during reset;
  - the first post-reset grant goes to requester 0.
